// File: rtl/nabp_swap_control.sv
// -----------------------------------------------------------------------------
// nabp_swap_control
// Angle scheduler and ping-pong arbiter for two NABP state-control units that
// share one shifter datapath. Angles kAngleStart..kAngleEnd (step kAngleStep)
// are handed out on next-angle requests; swap pulses move a filled unit into
// shifting so that only one unit shifts at a time; done rises once every issued
// angle has finished shifting.
//
// Ports:
//   clk                 system clock
//   reset               synchronous, active-high reset
//   start               one-cycle pulse, begins a pass from IDLE or DONE
//   sc0/1_next_angle    unit requests a new angle
//   sc0/1_fill_ready    unit waits in fill_done for a swap (level)
//   sc0/1_shift_done    unit finished shifting (pulse)
//   sc0/1_angle         registered angle for the unit
//   sc0/1_angle_valid   angle register holds an unfinished angle
//   sc0/1_swap          registered one-cycle swap pulse
//   done                all angles issued and shifted
// -----------------------------------------------------------------------------
module nabp_swap_control #(
    parameter int kAngleLength = 9,
    parameter int kAngleStart  = 0,
    parameter int kAngleEnd    = 179,
    parameter int kAngleStep   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    sc0_next_angle,
    input  logic                    sc1_next_angle,
    input  logic                    sc0_fill_ready,
    input  logic                    sc1_fill_ready,
    input  logic                    sc0_shift_done,
    input  logic                    sc1_shift_done,
    output logic [kAngleLength-1:0] sc0_angle,
    output logic [kAngleLength-1:0] sc1_angle,
    output logic                    sc0_angle_valid,
    output logic                    sc1_angle_valid,
    output logic                    sc0_swap,
    output logic                    sc1_swap,
    output logic                    done
);

    // Counter carries one extra bit so "past the end" never wraps back to a
    // small angle; sums get one more bit so two steps ahead cannot overflow.
    localparam int CW = kAngleLength + 1;
    localparam int SW = kAngleLength + 2;
    localparam logic [SW-1:0] END_S   = SW'(kAngleEnd);
    localparam logic [SW-1:0] STEP_S  = SW'(kAngleStep);
    localparam logic [CW-1:0] START_C = CW'(kAngleStart);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_r, state_s;
    logic [CW-1:0]           counter_r, counter_s;
    logic                    turn_r, turn_s;
    logic [1:0]              shifting_r, shifting_s;
    logic [1:0]              exhausted_r, exhausted_s;
    logic [kAngleLength-1:0] angle0_r, angle0_s;
    logic [kAngleLength-1:0] angle1_r, angle1_s;
    logic [1:0]              valid_r, valid_s;
    logic [1:0]              swap_r, swap_s;
    logic                    done_r, done_s;

    logic [SW-1:0]           cnt_w_s, cnt_p1_s, cnt_p2_s;
    logic                    first_ok_s, second_ok_s;
    logic [1:0]              req_s, ready_s, sdone_s;

    assign req_s   = {sc1_next_angle, sc0_next_angle};
    assign ready_s = {sc1_fill_ready, sc0_fill_ready};
    assign sdone_s = {sc1_shift_done, sc0_shift_done};

    // Next-state, angle grant, swap arbitration and completion logic.
    always_comb begin
        state_s     = state_r;
        counter_s   = counter_r;
        turn_s      = turn_r;
        shifting_s  = shifting_r;
        exhausted_s = exhausted_r;
        angle0_s    = angle0_r;
        angle1_s    = angle1_r;
        valid_s     = valid_r;
        swap_s      = 2'b00;
        done_s      = done_r;
        cnt_w_s     = {1'b0, counter_r};
        cnt_p1_s    = cnt_w_s + STEP_S;
        cnt_p2_s    = cnt_p1_s + STEP_S;
        first_ok_s  = (cnt_w_s <= END_S);
        second_ok_s = (cnt_p1_s <= END_S);

        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_s     = S_RUN;
                    counter_s   = START_C;
                    turn_s      = 1'b0;
                    shifting_s  = 2'b00;
                    exhausted_s = 2'b00;
                    valid_s     = 2'b00;
                    done_s      = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            S_RUN, S_DRAIN: begin
                // Angle grant: unit 0 takes the lower angle on a tie.
                if (req_s == 2'b11) begin
                    if (first_ok_s) begin
                        angle0_s   = counter_r[kAngleLength-1:0];
                        valid_s[0] = 1'b1;
                        if (second_ok_s) begin
                            angle1_s   = cnt_p1_s[kAngleLength-1:0];
                            valid_s[1] = 1'b1;
                            counter_s  = cnt_p2_s[CW-1:0];
                        end else begin
                            valid_s[1]     = 1'b0;
                            exhausted_s[1] = 1'b1;
                            counter_s      = cnt_p1_s[CW-1:0];
                        end
                    end else begin
                        valid_s     = 2'b00;
                        exhausted_s = 2'b11;
                    end
                end else if (req_s == 2'b01) begin
                    if (first_ok_s) begin
                        angle0_s   = counter_r[kAngleLength-1:0];
                        valid_s[0] = 1'b1;
                        counter_s  = cnt_p1_s[CW-1:0];
                    end else begin
                        valid_s[0]     = 1'b0;
                        exhausted_s[0] = 1'b1;
                    end
                end else if (req_s == 2'b10) begin
                    if (first_ok_s) begin
                        angle1_s   = counter_r[kAngleLength-1:0];
                        valid_s[1] = 1'b1;
                        counter_s  = cnt_p1_s[CW-1:0];
                    end else begin
                        valid_s[1]     = 1'b0;
                        exhausted_s[1] = 1'b1;
                    end
                end else begin
                    counter_s = counter_r;
                end

                // A stray shift_done on an idle unit clears an already-clear flag.
                shifting_s = shifting_r & ~sdone_s;

                // Swap arbitration looks at the registered flags only, so a
                // shift_done on the peer delays the swap by one cycle.
                if (exhausted_r[turn_r]) begin
                    turn_s = ~turn_r;
                end else if (ready_s[turn_r] && valid_r[turn_r] &&
                             !shifting_r[~turn_r] && !shifting_r[turn_r]) begin
                    swap_s[turn_r]     = 1'b1;
                    shifting_s[turn_r] = 1'b1;
                    turn_s             = ~turn_r;
                end else begin
                    turn_s = turn_r;
                end

                if (state_r == S_RUN) begin
                    if ({1'b0, counter_s} > END_S) begin
                        state_s = S_DRAIN;
                    end else begin
                        state_s = S_RUN;
                    end
                end else if ((exhausted_r == 2'b11) && (shifting_r == 2'b00)) begin
                    state_s = S_DONE;
                    done_s  = 1'b1;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            counter_r   <= START_C;
            turn_r      <= 1'b0;
            shifting_r  <= 2'b00;
            exhausted_r <= 2'b00;
            angle0_r    <= '0;
            angle1_r    <= '0;
            valid_r     <= 2'b00;
            swap_r      <= 2'b00;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            counter_r   <= counter_s;
            turn_r      <= turn_s;
            shifting_r  <= shifting_s;
            exhausted_r <= exhausted_s;
            angle0_r    <= angle0_s;
            angle1_r    <= angle1_s;
            valid_r     <= valid_s;
            swap_r      <= swap_s;
            done_r      <= done_s;
        end
    end

    assign sc0_angle       = angle0_r;
    assign sc1_angle       = angle1_r;
    assign sc0_angle_valid = valid_r[0];
    assign sc1_angle_valid = valid_r[1];
    assign sc0_swap        = swap_r[0];
    assign sc1_swap        = swap_r[1];
    assign done            = done_r;

endmodule

// File: tb/tb_nabp_swap_control.sv
// -----------------------------------------------------------------------------
// Testbench for nabp_swap_control. Three instances share one stimulus set:
//   dut_a : default parameters (0..179 step 1)
//   dut_b : 0..5 step 2
//   dut_c : 8-bit angles, 0..255 step 1
// Directed steps cover reset, grant latency, tie-breaking, swap interlock,
// exhaustion and restart; a randomized phase drives two behavioural units
// against dut_a and checks issue order, exclusive shifting and completion.
// -----------------------------------------------------------------------------
module tb_nabp_swap_control;

    logic clk;
    logic reset, start;
    logic sc0_next_angle, sc1_next_angle;
    logic sc0_fill_ready, sc1_fill_ready;
    logic sc0_shift_done, sc1_shift_done;

    logic [8:0] a_sc0_angle, a_sc1_angle, b_sc0_angle, b_sc1_angle;
    logic [7:0] c_sc0_angle, c_sc1_angle;
    logic a_v0, a_v1, a_sw0, a_sw1, a_done;
    logic b_v0, b_v1, b_sw0, b_sw1, b_done;
    logic c_v0, c_v1, c_sw0, c_sw1, c_done;

    int checks = 0;
    int errors = 0;

    nabp_swap_control dut_a (
        .clk(clk), .reset(reset), .start(start),
        .sc0_next_angle(sc0_next_angle), .sc1_next_angle(sc1_next_angle),
        .sc0_fill_ready(sc0_fill_ready), .sc1_fill_ready(sc1_fill_ready),
        .sc0_shift_done(sc0_shift_done), .sc1_shift_done(sc1_shift_done),
        .sc0_angle(a_sc0_angle), .sc1_angle(a_sc1_angle),
        .sc0_angle_valid(a_v0), .sc1_angle_valid(a_v1),
        .sc0_swap(a_sw0), .sc1_swap(a_sw1), .done(a_done)
    );

    nabp_swap_control #(.kAngleLength(9), .kAngleStart(0), .kAngleEnd(5), .kAngleStep(2)) dut_b (
        .clk(clk), .reset(reset), .start(start),
        .sc0_next_angle(sc0_next_angle), .sc1_next_angle(sc1_next_angle),
        .sc0_fill_ready(sc0_fill_ready), .sc1_fill_ready(sc1_fill_ready),
        .sc0_shift_done(sc0_shift_done), .sc1_shift_done(sc1_shift_done),
        .sc0_angle(b_sc0_angle), .sc1_angle(b_sc1_angle),
        .sc0_angle_valid(b_v0), .sc1_angle_valid(b_v1),
        .sc0_swap(b_sw0), .sc1_swap(b_sw1), .done(b_done)
    );

    nabp_swap_control #(.kAngleLength(8), .kAngleStart(0), .kAngleEnd(255), .kAngleStep(1)) dut_c (
        .clk(clk), .reset(reset), .start(start),
        .sc0_next_angle(sc0_next_angle), .sc1_next_angle(sc1_next_angle),
        .sc0_fill_ready(sc0_fill_ready), .sc1_fill_ready(sc1_fill_ready),
        .sc0_shift_done(sc0_shift_done), .sc1_shift_done(sc1_shift_done),
        .sc0_angle(c_sc0_angle), .sc1_angle(c_sc1_angle),
        .sc0_angle_valid(c_v0), .sc1_angle_valid(c_v1),
        .sc0_swap(c_sw0), .sc1_swap(c_sw1), .done(c_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, "_ang0"}, a_sc0_angle, 0);
        chk({tag, "_ang1"}, a_sc1_angle, 0);
        chk({tag, "_v0"}, a_v0, 0);
        chk({tag, "_v1"}, a_v1, 0);
        chk({tag, "_sw0"}, a_sw0, 0);
        chk({tag, "_sw1"}, a_sw1, 0);
        chk({tag, "_done"}, a_done, 0);
    endtask

    task automatic do_reset_start();
        reset = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Behavioural unit states for the randomized phase.
    localparam int U_REQ = 0, U_FILL = 1, U_READY = 2, U_SHIFT = 3, U_STOP = 4;
    localparam int A_END = 179, A_STEP = 1, A_TOTAL = 180, BUDGET = 20000;

    int  ust [2];
    int  utim [2];
    int  uang [2];
    bit  seen [0:511];
    int  exp_next, shifted, cyc, nseen;
    logic [1:0] obs_swap, obs_valid;
    logic [8:0] obs_ang [2];

    initial begin
        reset = 1'b1; start = 1'b0;
        sc0_next_angle = 1'b0; sc1_next_angle = 1'b0;
        sc0_fill_ready = 1'b0; sc1_fill_ready = 1'b0;
        sc0_shift_done = 1'b0; sc1_shift_done = 1'b0;

        // ---------------- reset state and basic grants (dut_a) ----------------
        step();
        step();
        chk_a_zero("reset");
        reset = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        sc0_next_angle = 1'b1; step(); sc0_next_angle = 1'b0;
        chk("grant0_ang", a_sc0_angle, 0);
        chk("grant0_val", a_v0, 1);
        sc1_next_angle = 1'b1; step(); sc1_next_angle = 1'b0;
        chk("grant1_ang", a_sc1_angle, 1);
        chk("grant1_val", a_v1, 1);
        sc0_next_angle = 1'b1; step(); sc0_next_angle = 1'b0;
        sc1_next_angle = 1'b1; step(); sc1_next_angle = 1'b0;
        sc0_next_angle = 1'b1; sc1_next_angle = 1'b1; step();
        sc0_next_angle = 1'b0; sc1_next_angle = 1'b0;
        chk("tie_ang0", a_sc0_angle, 4);
        chk("tie_ang1", a_sc1_angle, 5);
        sc0_next_angle = 1'b1; step(); sc0_next_angle = 1'b0;
        chk("after_tie", a_sc0_angle, 6);

        // ---------------- swap interlock (dut_a) ----------------
        sc0_fill_ready = 1'b1; step();
        chk("swap0_pulse", a_sw0, 1);
        chk("swap1_quiet", a_sw1, 0);
        step();
        chk("swap0_single", a_sw0, 0);
        sc0_fill_ready = 1'b0; sc1_fill_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("swap1_blocked", a_sw1, 0);
        end
        sc0_shift_done = 1'b1; step(); sc0_shift_done = 1'b0;
        chk("swap1_preclear", a_sw1, 0);
        step();
        chk("swap1_after", a_sw1, 1);
        sc1_fill_ready = 1'b0; step();
        chk("swap1_single", a_sw1, 0);
        chk("run_not_done", a_done, 0);
        sc1_shift_done = 1'b1; step(); sc1_shift_done = 1'b0;

        // ---------------- reset while unit 1 shifts (dut_a) ----------------
        do_reset_start();
        sc0_next_angle = 1'b1; step(); sc0_next_angle = 1'b0;
        sc1_next_angle = 1'b1; step(); sc1_next_angle = 1'b0;
        sc0_fill_ready = 1'b1; step(); sc0_fill_ready = 1'b0;
        sc0_shift_done = 1'b1; step(); sc0_shift_done = 1'b0;
        sc1_fill_ready = 1'b1; step();
        chk("pre_reset_swap1", a_sw1, 1);
        reset = 1'b1; step(); reset = 1'b0; sc1_fill_ready = 1'b0;
        chk_a_zero("midreset");
        sc0_next_angle = 1'b1; step(); sc0_next_angle = 1'b0;
        chk("idle_ignore_val", a_v0, 0);
        chk("idle_ignore_ang", a_sc0_angle, 0);

        // ---------------- stepped range 0..5 step 2 (dut_b) ----------------
        do_reset_start();
        sc0_next_angle = 1'b1; step(); sc0_next_angle = 1'b0;
        chk("b_ang0", b_sc0_angle, 0);
        chk("b_val0", b_v0, 1);
        sc1_next_angle = 1'b1; step(); sc1_next_angle = 1'b0;
        chk("b_ang1", b_sc1_angle, 2);
        sc0_fill_ready = 1'b1; step(); sc0_fill_ready = 1'b0;
        chk("b_swap0", b_sw0, 1);
        sc0_shift_done = 1'b1; step(); sc0_shift_done = 1'b0;
        sc0_next_angle = 1'b1; step(); sc0_next_angle = 1'b0;
        chk("b_ang0_4", b_sc0_angle, 4);
        chk("b_val0_4", b_v0, 1);
        sc1_fill_ready = 1'b1; step(); sc1_fill_ready = 1'b0;
        chk("b_swap1", b_sw1, 1);
        sc1_shift_done = 1'b1; step(); sc1_shift_done = 1'b0;
        sc1_next_angle = 1'b1; step(); sc1_next_angle = 1'b0;
        chk("b_exh1_val", b_v1, 0);
        chk("b_exh1_hold", b_sc1_angle, 2);
        chk("b_not_done1", b_done, 0);
        sc0_fill_ready = 1'b1; step(); sc0_fill_ready = 1'b0;
        chk("b_swap0_last", b_sw0, 1);
        sc0_shift_done = 1'b1; step(); sc0_shift_done = 1'b0;
        chk("b_not_done2", b_done, 0);
        sc0_next_angle = 1'b1; step(); sc0_next_angle = 1'b0;
        chk("b_exh0_val", b_v0, 0);
        chk("b_not_done3", b_done, 0);
        step();
        chk("b_done", b_done, 1);
        start = 1'b1; step(); start = 1'b0;
        chk("b_restart_clr", b_done, 0);
        sc0_next_angle = 1'b1; step(); sc0_next_angle = 1'b0;
        chk("b_restart_ang", b_sc0_angle, 0);
        chk("b_restart_val", b_v0, 1);

        // ---------------- full 8-bit range, no wrap (dut_c) ----------------
        do_reset_start();
        sc0_next_angle = 1'b1;
        for (int i = 0; i < 256; i++) begin
            step();
            chk("c_seq", {23'd0, c_v0, c_sc0_angle}, 32'h100 + i);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            chk("c_nowrap", {23'd0, c_v0, c_sc0_angle}, 32'h0FF);
        end
        sc0_next_angle = 1'b0;

        // ---------------- randomized units against dut_a ----------------
        do_reset_start();
        for (int i = 0; i < 512; i++) seen[i] = 1'b0;
        for (int u = 0; u < 2; u++) begin
            ust[u] = U_REQ; utim[u] = 0; uang[u] = 0;
        end
        exp_next = 0;
        shifted  = 0;
        cyc      = 0;
        while ((cyc < BUDGET) && !((ust[0] == U_STOP) && (ust[1] == U_STOP) && (a_done === 1'b1))) begin
            sc0_next_angle = (ust[0] == U_REQ);
            sc1_next_angle = (ust[1] == U_REQ);
            sc0_fill_ready = (ust[0] == U_READY);
            sc1_fill_ready = (ust[1] == U_READY);
            sc0_shift_done = (ust[0] == U_SHIFT) && (utim[0] == 0);
            sc1_shift_done = (ust[1] == U_SHIFT) && (utim[1] == 0);
            step();
            cyc++;
            obs_swap   = {a_sw1, a_sw0};
            obs_valid  = {a_v1, a_v0};
            obs_ang[0] = a_sc0_angle;
            obs_ang[1] = a_sc1_angle;
            if (obs_swap != 2'b00) chk("r_swap_excl", (obs_swap != 2'b11), 1);
            for (int u = 0; u < 2; u++) begin
                if (obs_swap[u]) begin
                    chk("r_swap_ready", (ust[u] == U_READY), 1);
                    chk("r_peer_idle", (ust[1-u] != U_SHIFT), 1);
                    chk("r_dup_shift", seen[uang[u]], 0);
                    seen[uang[u]] = 1'b1;
                end
            end
            if (shifted < A_TOTAL) chk("r_early_done", a_done, 0);
            for (int u = 0; u < 2; u++) begin
                case (ust[u])
                    U_REQ: begin
                        chk("r_valid", obs_valid[u], (exp_next <= A_END));
                        if (exp_next <= A_END) begin
                            chk("r_angle", obs_ang[u], exp_next);
                            uang[u]  = exp_next;
                            exp_next = exp_next + A_STEP;
                            ust[u]   = U_FILL;
                            utim[u]  = $urandom_range(0, 4);
                        end else begin
                            ust[u] = U_STOP;
                        end
                    end
                    U_FILL: begin
                        if (utim[u] == 0) ust[u] = U_READY;
                        else utim[u]--;
                    end
                    U_READY: begin
                        if (obs_swap[u]) begin
                            ust[u]  = U_SHIFT;
                            utim[u] = $urandom_range(0, 6);
                        end
                    end
                    U_SHIFT: begin
                        if (utim[u] == 0) begin
                            shifted++;
                            ust[u] = U_REQ;
                        end else begin
                            utim[u]--;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
        sc0_next_angle = 1'b0; sc1_next_angle = 1'b0;
        sc0_fill_ready = 1'b0; sc1_fill_ready = 1'b0;
        sc0_shift_done = 1'b0; sc1_shift_done = 1'b0;
        chk("r_in_budget", (cyc < BUDGET), 1);
        chk("r_done", a_done, 1);
        chk("r_shifted", shifted, A_TOTAL);
        nseen = 0;
        for (int i = 0; i < 512; i++) nseen += int'(seen[i]);
        chk("r_coverage", nseen, A_TOTAL);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
